// File: rtl/pairing_io_bridge.sv
// Host word-stream front end for the Tate pairing core.
// Loads four operands, runs the core, streams the result back.
`ifndef M
`define M 97
`endif
`ifndef WIDTH
`define WIDTH (2*`M-1)
`endif
`ifndef W6
`define W6 (12*`M-1)
`endif

module pairing_io_bridge #(
    parameter int DW  = 32,
    parameter int NWI = (2*`M + DW - 1) / DW,
    parameter int NWO = (12*`M + DW - 1) / DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy,
    output logic            core_reset,
    output logic [`WIDTH:0] core_x1,
    output logic [`WIDTH:0] core_y1,
    output logic [`WIDTH:0] core_x2,
    output logic [`WIDTH:0] core_y2,
    input  logic            core_done,
    input  logic [`W6:0]    core_out
);

    localparam int OPW = 2*`M;
    localparam int RSW = 12*`M;
    localparam int IW  = (NWI > 1) ? $clog2(NWI) : 1;
    localparam int RW  = (NWO > 1) ? $clog2(NWO) : 1;
    localparam logic [IW-1:0] WLAST = IW'(NWI-1);
    localparam logic [RW-1:0] RLAST = RW'(NWO-1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [OPW-1:0]    op_q [4];
    logic [1:0]        osel_q;
    logic [IW-1:0]     widx_q;
    logic [RW-1:0]     ridx_q;
    logic [RSW-1:0]    res_q;
    logic [NWO*DW-1:0] res_pad;
    logic              in_fire;
    logic              out_fire;
    logic              load_end;
    logic              drain_end;

    assign in_fire   = in_valid && (state_q == S_LOAD);
    assign out_fire  = out_ready && (state_q == S_DRAIN);
    assign load_end  = in_fire && (osel_q == 2'd3) && (widx_q == WLAST);
    assign drain_end = out_fire && (ridx_q == RLAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (load_end) state_d = S_KICK;
            S_KICK:  state_d = S_WAIT;
            S_WAIT:  if (core_done) state_d = S_DRAIN;
            S_DRAIN: if (drain_end) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    // Bits of the final slot past the operand width are simply never stored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                op_q[i] <= '0;
            end
            osel_q <= '0;
            widx_q <= '0;
        end else if (in_fire) begin
            for (int b = 0; b < OPW; b++) begin
                if ((b / DW) == int'(widx_q)) begin
                    op_q[osel_q][b] <= in_data[b % DW];
                end
            end
            if (widx_q == WLAST) begin
                widx_q <= '0;
                osel_q <= osel_q + 2'd1;
            end else begin
                widx_q <= widx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q  <= '0;
            ridx_q <= '0;
        end else if (state_q == S_WAIT && core_done) begin
            res_q  <= core_out;
            ridx_q <= '0;
        end else if (out_fire) begin
            ridx_q <= drain_end ? '0 : ridx_q + 1'b1;
        end
    end

    assign res_pad = (NWO*DW)'(res_q);

    assign in_ready   = (state_q == S_LOAD);
    assign core_reset = (state_q != S_WAIT);
    assign busy       = (state_q != S_LOAD);
    assign out_valid  = (state_q == S_DRAIN);
    assign out_last   = (state_q == S_DRAIN) && (ridx_q == RLAST);
    assign out_data   = (state_q == S_DRAIN) ?
                        res_pad[ridx_q*DW +: DW] : '0;

    assign core_x1 = op_q[0];
    assign core_y1 = op_q[1];
    assign core_x2 = op_q[2];
    assign core_y2 = op_q[3];

endmodule

// File: tb/tb_pairing_io_bridge.sv
// Randomized scoreboard bench for pairing_io_bridge
// with a stub pairing core.
`ifndef M
`define M 97
`endif
`ifndef WIDTH
`define WIDTH (2*`M-1)
`endif
`ifndef W6
`define W6 (12*`M-1)
`endif

module tb_pairing_io_bridge;

    localparam int DW  = 32;
    localparam int NWI = 7;
    localparam int NWO = 37;
    localparam int OPW = 2*`M;
    localparam int RSW = 12*`M;
    localparam int NIN = 4*NWI;

    logic            clk = 1'b0;
    logic            reset;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
    logic            core_reset;
    logic [`WIDTH:0] core_x1, core_y1, core_x2, core_y2;
    logic            core_done;
    logic [`W6:0]    core_out;
    logic            stub_done = 1'b0;
    logic            stray_done;
    int              stub_cnt = 0;

    assign core_done = stub_done | stray_done;

    pairing_io_bridge #(.DW(DW), .NWI(NWI), .NWO(NWO)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .core_reset(core_reset),
        .core_x1(core_x1), .core_y1(core_y1),
        .core_x2(core_x2), .core_y2(core_y2),
        .core_done(core_done), .core_out(core_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stub core: done 50 cycles after its reset drops, held until reset.
    always @(posedge clk) begin
        if (core_reset) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == 49) stub_done <= 1'b1;
        end
    end

    int rmode = 0;
    int rphase = 0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = (rphase % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            rphase++;
        end
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    logic          held_v = 1'b0;
    logic [DW-1:0] held_d;
    logic          held_l;

    always @(negedge clk) begin
        if (!reset) begin
            held_v = 1'b0;
        end else if (out_valid) begin
            if (held_v) begin
                chk("stall_data", 256'(out_data), 256'(held_d));
                chk("stall_last", 256'(out_last), 256'(held_l));
            end
            if (out_ready) begin
                held_v = 1'b0;
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_word: got %0h expected none",
                             out_data);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("out_data", 256'(out_data), 256'(mon_e.d));
                    chk("out_last", 256'(out_last), 256'(mon_e.l));
                end
            end else begin
                held_v = 1'b1;
                held_d = out_data;
                held_l = out_last;
            end
        end
    end

    logic [DW-1:0] ld_words [NIN];

    function automatic logic [OPW-1:0] op_model(input int i);
        logic [NWI*DW-1:0] t;
        for (int k = 0; k < NWI; k++) t[k*DW +: DW] = ld_words[i*NWI+k];
        return t[OPW-1:0];
    endfunction

    function automatic logic byte_bit(input int base, input int bitpos);
        int v;
        v = (base + bitpos / 8) & 255;
        return 1'((v >> (bitpos % 8)) & 1);
    endfunction

    task automatic check_ops(input string tag);
        chk({tag, "_x1"}, 256'(core_x1), 256'(op_model(0)));
        chk({tag, "_y1"}, 256'(core_y1), 256'(op_model(1)));
        chk({tag, "_x2"}, 256'(core_x2), 256'(op_model(2)));
        chk({tag, "_y2"}, 256'(core_y2), 256'(op_model(3)));
    endtask

    task automatic rand_words();
        for (int i = 0; i < NIN; i++) ld_words[i] = $urandom;
    endtask

    task automatic do_load(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = ld_words[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        sbq.delete();
        chk({tag, "_in_ready"}, 256'(in_ready), 256'(1));
        chk({tag, "_out_valid"}, 256'(out_valid), 256'(0));
        chk({tag, "_out_last"}, 256'(out_last), 256'(0));
        chk({tag, "_out_data"}, 256'(out_data), 256'(0));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_core_reset"}, 256'(core_reset), 256'(1));
        chk({tag, "_ops"}, 256'(core_x1 | core_y1 | core_x2 | core_y2),
            256'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic load_and_kick(input bit gaps);
        do_load(NIN, gaps);
        chk("kick_busy", 256'(busy), 256'(1));
        chk("kick_in_ready", 256'(in_ready), 256'(0));
        chk("kick_core_reset", 256'(core_reset), 256'(1));
        @(posedge clk);
        #1;
        chk("wait_core_reset", 256'(core_reset), 256'(0));
        chk("wait_busy", 256'(busy), 256'(1));
    endtask

    // Runs one pairing: expected words go to the scoreboard up front.
    task automatic run_pair(input int base, input int mode,
                            input bit stray, input int rst_at);
        logic [DW-1:0] w;
        int n;
        bit seen;
        rmode = mode;
        for (int b = 0; b < RSW; b++) core_out[b] = byte_bit(base, b);
        for (int k = 0; k < NWO; k++) begin
            for (int j = 0; j < DW; j++) begin
                w[j] = (k*DW + j < RSW) ? byte_bit(base, k*DW + j) : 1'b0;
            end
            sbq.push_back('{d: w, l: (k == NWO-1)});
        end
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (core_done) begin
                seen = 1'b1;
            end else if (stray) begin
                in_valid = (i == 5);
                in_data  = $urandom;
            end
        end
        in_valid = 1'b0;
        chk("done_seen", 256'(seen), 256'(1));
        chk("pre_drain_valid", 256'(out_valid), 256'(0));
        @(posedge clk);
        #1;
        chk("drain_start_valid", 256'(out_valid), 256'(1));
        n = 0;
        while (out_valid && n < 500) begin
            if (rst_at >= 0 && NWO - sbq.size() == rst_at) begin
                async_reset("drain_rst");
                return;
            end
            in_valid = stray && (n == 3);
            in_data  = $urandom;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("drain_bounded", 256'(n < 500), 256'(1));
        chk("drain_empty", 256'(sbq.size()), 256'(0));
        chk("post_in_ready", 256'(in_ready), 256'(1));
        chk("post_core_reset", 256'(core_reset), 256'(1));
        chk("post_out_last", 256'(out_last), 256'(0));
        if (mode == 0) chk("drain_cycles", 256'(n), 256'(NWO));
        check_ops("post_drain");
        if (stray) begin
            stray_done = 1'b1;
            @(posedge clk);
            #1;
            stray_done = 1'b0;
            chk("stray_done_ready", 256'(in_ready), 256'(1));
            chk("stray_done_busy", 256'(busy), 256'(0));
            @(posedge clk);
            #1;
            chk("stray_done_valid", 256'(out_valid), 256'(0));
            chk("stray_done_creset", 256'(core_reset), 256'(1));
        end
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        stray_done = 1'b0;
        core_out   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        rand_words();
        do_load(3, 1'b0);
        async_reset("reset");
        chk("rel_in_ready", 256'(in_ready), 256'(1));
        chk("rel_core_reset", 256'(core_reset), 256'(1));

        for (int i = 0; i < NIN; i++) ld_words[i] = DW'(i + 1);
        load_and_kick(1'b0);
        chk("x1_w0", 256'(core_x1[31:0]), 256'(1));
        chk("x1_w6", 256'(core_x1[193:192]), 256'(3));
        chk("y2_w0", 256'(core_y2[31:0]), 256'(22));
        check_ops("dir");
        run_pair(0, 0, 1'b0, -1);

        rand_words();
        load_and_kick(1'b1);
        check_ops("bp");
        run_pair(int'($urandom_range(0, 255)), 1, 1'b1, -1);

        rand_words();
        load_and_kick(1'b1);
        check_ops("rnd");
        run_pair(int'($urandom_range(0, 255)), 2, 1'b1, -1);

        rand_words();
        do_load(10, 1'b0);
        async_reset("load_rst");
        rand_words();
        load_and_kick(1'b0);
        check_ops("after_load_rst");
        run_pair(int'($urandom_range(0, 255)), 2, 1'b0, 5);
        chk("after_drain_rst", 256'(out_valid), 256'(0));

        rand_words();
        load_and_kick(1'b1);
        check_ops("after_drain_rst");
        run_pair(int'($urandom_range(0, 255)), 0, 1'b0, -1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
